instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_if.sv | 26 ++
 rtl/instruction_fetch.sv | 116 +++++++++++
 tb/tb_instruction_fetch.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: program-memory request/ack, pipeline control and decode handoff.
// master = fetch unit, slave = memory/pipeline environment.
interface instruction_fetch_if;
  logic [31:0] o_pc;
  logic        o_instruction_request;
  logic [31:0] i_instruction;
  logic        i_ack;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_if_valid;
  logic        i_id_ready;
  logic [31:0] o_if_instruction;
  logic [31:0] o_if_pc;
  logic        o_misaligned;

  modport master (
    output o_pc, o_instruction_request, o_if_valid, o_if_instruction, o_if_pc, o_misaligned,
    input  i_instruction, i_ack, i_stall, i_redirect, i_redirect_pc, i_id_ready
  );

  modport slave (
    input  o_pc, o_instruction_request, o_if_valid, o_if_instruction, o_if_pc, o_misaligned,
    output i_instruction, i_ack, i_stall, i_redirect, i_redirect_pc, i_id_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues program-memory requests, holds one fetched
// instruction for decode, and handles redirects including ones that land mid-request.
//
// state  | meaning
// S_BOOT | first cycle after reset, no request
// S_RUN  | request issued whenever the pipeline allows
// S_WAIT | request outstanding, waiting for ack
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  instruction_fetch_if.master  bus
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        if_valid_q, if_valid_d;
  logic        misaligned_q, misaligned_d;
  logic        discard_q, discard_d;
  logic        issue, req, capture, accept;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = {bus.i_redirect_pc[31:2], 2'b00};
  assign accept       = if_valid_q && bus.i_id_ready;
  assign issue        = !bus.i_stall && !bus.i_redirect && (!if_valid_q || bus.i_id_ready);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      if_instr_q   <= 32'h0000_0013;
      if_pc_q      <= 32'h0000_0000;
      redir_pc_q   <= 32'h0000_0000;
      if_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      redir_pc_q   <= redir_pc_d;
      if_valid_q   <= if_valid_d;
      misaligned_q <= misaligned_d;
      discard_q    <= discard_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (issue && !bus.i_ack) state_d = S_WAIT;
      S_WAIT:  if (bus.i_ack) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    case (state_q)
      S_RUN:   req = issue;
      S_WAIT:  req = 1'b1;
      default: req = 1'b0;
    endcase
    if (i_rst) req = 1'b0;

    // an ack for a request that a redirect has overtaken is consumed but dropped
    capture = req && bus.i_ack && !discard_q && !bus.i_redirect;

    pc_d         = pc_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    if_valid_d   = if_valid_q;
    redir_pc_d   = redir_pc_q;
    discard_d    = discard_q;
    misaligned_d = bus.i_redirect && (bus.i_redirect_pc[1:0] != 2'b00);

    if (capture) begin
      if_instr_d = bus.i_instruction;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      pc_d       = pc_q + 32'd4;
    end else if (accept) begin
      if_valid_d = 1'b0;
    end

    if (state_q == S_WAIT) begin
      if (bus.i_redirect) begin
        redir_pc_d = redirect_tgt;
        discard_d  = 1'b1;
        if_valid_d = 1'b0;
      end
      if (bus.i_ack && (discard_q || bus.i_redirect)) begin
        pc_d      = bus.i_redirect ? redirect_tgt : redir_pc_q;
        discard_d = 1'b0;
      end
    end else if (bus.i_redirect) begin
      pc_d       = redirect_tgt;
      if_valid_d = 1'b0;
    end
  end

  assign bus.o_pc                  = pc_q;
  assign bus.o_instruction_request = req;
  assign bus.o_if_valid            = if_valid_q;
  assign bus.o_if_instruction      = if_instr_q;
  assign bus.o_if_pc               = if_pc_q;
  assign bus.o_misaligned          = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by randomized traffic
// checked against a program-order reference model.
module tb_instruction_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic i_clk = 1'b0;
  logic i_rst;
  int   n_checks = 0;
  int   n_errors = 0;

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0013_5A5A;
  endfunction

  // combinational program memory
  assign bus.i_instruction = mem_word(bus.o_pc);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  logic [31:0] tgt, prev_tgt, prev_pc, prev_if_pc, prev_if_instr, exp_pc;
  logic        prev_req, prev_ack, prev_redir, prev_valid, prev_ready, outstanding;
  int          accepts;

  initial begin
    i_rst             = 1'b1;
    bus.i_ack         = 1'b1;
    bus.i_stall       = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 32'h0;
    bus.i_id_ready    = 1'b1;

    // reset release and sequential fetch
    tick();
    check_val("req_in_reset", bus.o_instruction_request, 1'b0);
    tick();
    i_rst = 1'b0;
    #1;
    check_val("rst_req", bus.o_instruction_request, 1'b0);
    check_val("rst_pc", bus.o_pc, RESET_PC);
    check_val("rst_valid", bus.o_if_valid, 1'b0);
    check_val("rst_instr", bus.o_if_instruction, 32'h0000_0013);
    check_val("rst_if_pc", bus.o_if_pc, 32'h0);
    check_val("rst_misaligned", bus.o_misaligned, 1'b0);
    tick();
    check_val("run_req", bus.o_instruction_request, 1'b1);
    check_val("run_pc0", bus.o_pc, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("seq_valid", bus.o_if_valid, 1'b1);
      check_val("seq_if_pc", bus.o_if_pc, 32'(4 * k));
      check_val("seq_instr", bus.o_if_instruction, mem_word(32'(4 * k)));
    end

    // decode back-pressure for 3 cycles at if_pc=0x8
    bus.i_id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      #1;
      check_val("bp_req", bus.o_instruction_request, 1'b0);
      check_val("bp_if_pc", bus.o_if_pc, 32'h8);
      check_val("bp_instr", bus.o_if_instruction, mem_word(32'h8));
      check_val("bp_pc", bus.o_pc, 32'hC);
    end
    tick();
    bus.i_id_ready = 1'b1;
    #1;
    check_val("bp_resume_req", bus.o_instruction_request, 1'b1);
    check_val("bp_resume_pc", bus.o_pc, 32'hC);
    tick();
    check_val("bp_next_if_pc", bus.o_if_pc, 32'hC);

    // delayed ack at 0x10 with stall pulse during the wait
    bus.i_ack = 1'b0;
    #1;
    check_val("wait_issue_pc", bus.o_pc, 32'h10);
    tick();
    bus.i_stall = 1'b1;
    #1;
    check_val("wait_req_stall", bus.o_instruction_request, 1'b1);
    check_val("wait_pc_stall", bus.o_pc, 32'h10);
    check_val("wait_valid", bus.o_if_valid, 1'b0);
    tick();
    bus.i_stall    = 1'b0;
    bus.i_id_ready = 1'b0;
    #1;
    check_val("wait_req_2", bus.o_instruction_request, 1'b1);
    check_val("wait_pc_2", bus.o_pc, 32'h10);
    tick();
    bus.i_ack      = 1'b1;
    bus.i_id_ready = 1'b1;
    #1;
    check_val("wait_req_ack", bus.o_instruction_request, 1'b1);
    tick();
    check_val("wait_cap_valid", bus.o_if_valid, 1'b1);
    check_val("wait_cap_if_pc", bus.o_if_pc, 32'h10);
    check_val("wait_cap_instr", bus.o_if_instruction, mem_word(32'h10));
    check_val("wait_next_pc", bus.o_pc, 32'h14);

    // misaligned redirect in S_RUN
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h0000_0102;
    #1;
    check_val("redir_no_req", bus.o_instruction_request, 1'b0);
    tick();
    bus.i_redirect = 1'b0;
    #1;
    check_val("redir_valid", bus.o_if_valid, 1'b0);
    check_val("redir_mis", bus.o_misaligned, 1'b1);
    check_val("redir_pc", bus.o_pc, 32'h100);
    tick();
    check_val("redir_mis_clr", bus.o_misaligned, 1'b0);
    check_val("redir_if_pc", bus.o_if_pc, 32'h100);

    // redirect during S_WAIT discards the outstanding ack
    bus.i_ack = 1'b0;
    tick();
    check_val("wr_req", bus.o_instruction_request, 1'b1);
    check_val("wr_pc", bus.o_pc, 32'h104);
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h0000_0200;
    tick();
    bus.i_redirect = 1'b0;
    #1;
    check_val("wr_pc_held", bus.o_pc, 32'h104);
    check_val("wr_req_held", bus.o_instruction_request, 1'b1);
    bus.i_ack = 1'b1;
    tick();
    check_val("wr_discard_valid", bus.o_if_valid, 1'b0);
    check_val("wr_new_pc", bus.o_pc, 32'h200);
    check_val("wr_new_req", bus.o_instruction_request, 1'b1);
    tick();
    check_val("wr_if_pc", bus.o_if_pc, 32'h200);

    // wrap at the top of the address space
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.i_redirect = 1'b0;
    #1;
    check_val("wrap_pc", bus.o_pc, 32'hFFFF_FFFC);
    tick();
    check_val("wrap_if_pc", bus.o_if_pc, 32'hFFFF_FFFC);
    check_val("wrap_next_pc", bus.o_pc, 32'h0);
    tick();
    check_val("wrap_if_pc0", bus.o_if_pc, 32'h0);

    // reset in the middle of an outstanding request
    bus.i_ack = 1'b0;
    tick();
    check_val("mr_wait_pc", bus.o_pc, 32'h4);
    i_rst     = 1'b1;
    bus.i_ack = 1'b1;
    #1;
    check_val("mr_req_in_rst", bus.o_instruction_request, 1'b0);
    tick();
    i_rst = 1'b0;
    #1;
    check_val("mr_pc", bus.o_pc, RESET_PC);
    check_val("mr_req", bus.o_instruction_request, 1'b0);
    check_val("mr_valid", bus.o_if_valid, 1'b0);

    // randomized traffic against the program-order model
    i_rst = 1'b1;
    tick();
    tick();
    i_rst         = 1'b0;
    exp_pc        = RESET_PC;
    prev_req      = 1'b0;
    prev_ack      = 1'b0;
    prev_redir    = 1'b0;
    prev_valid    = 1'b0;
    prev_ready    = 1'b0;
    prev_tgt      = 32'h0;
    prev_pc       = 32'h0;
    prev_if_pc    = 32'h0;
    prev_if_instr = 32'h0;
    accepts       = 0;
    for (int c = 0; c < 4000; c++) begin
      bus.i_stall    = ($urandom_range(0, 9) < 2);
      bus.i_id_ready = ($urandom_range(0, 3) != 0);
      bus.i_ack      = ($urandom_range(0, 9) < 7);
      bus.i_redirect = ($urandom_range(0, 29) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
      bus.i_redirect_pc = tgt;
      #1;
      outstanding = prev_req && !prev_ack;
      check_val("rnd_misaligned", bus.o_misaligned, prev_redir && (prev_tgt[1:0] != 2'b00));
      if (outstanding) begin
        check_val("rnd_wait_req", bus.o_instruction_request, 1'b1);
        check_val("rnd_wait_pc", bus.o_pc, prev_pc);
      end else if (bus.i_stall || bus.i_redirect || (bus.o_if_valid && !bus.i_id_ready)) begin
        check_val("rnd_no_req", bus.o_instruction_request, 1'b0);
      end
      if (prev_valid && !prev_ready && !prev_redir) begin
        check_val("rnd_hold_valid", bus.o_if_valid, 1'b1);
        check_val("rnd_hold_if_pc", bus.o_if_pc, prev_if_pc);
        check_val("rnd_hold_instr", bus.o_if_instruction, prev_if_instr);
      end
      if (bus.o_if_valid && bus.i_id_ready) begin
        check_val("rnd_accept_pc", bus.o_if_pc, exp_pc);
        check_val("rnd_accept_instr", bus.o_if_instruction, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        accepts++;
      end
      if (bus.i_redirect) exp_pc = {tgt[31:2], 2'b00};
      prev_req      = bus.o_instruction_request;
      prev_ack      = bus.i_ack;
      prev_pc       = bus.o_pc;
      prev_redir    = bus.i_redirect;
      prev_tgt      = tgt;
      prev_valid    = bus.o_if_valid;
      prev_ready    = bus.i_id_ready;
      prev_if_pc    = bus.o_if_pc;
      prev_if_instr = bus.o_if_instruction;
      tick();
    end
    check_val("rnd_progress", 32'(accepts > 400), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
